// File: rtl/dac_spi_pkg.sv
// Shared definitions for the MCP4911-style DAC serialiser: frame layout,
// FSM state encoding and counter widths.
package dac_spi_pkg;

  localparam int FRAME_BITS = 16;

  // Frame layout: {cfg[15:12], sample[11:2], don't-care[1:0]}
  localparam int CFG_MSB  = 15;
  localparam int CFG_LSB  = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;

  localparam int PHASE_W = 8;  // phase counter, holds 0..CLK_DIV-1
  localparam int BIT_W   = 4;  // bit counter, 15 down to 0

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CS_HOLD = 3'd2,
    CS_HIGH = 3'd3,
    LDAC    = 3'd4
  } state_t;

  // Assemble one write frame from the config nibble and a 10-bit sample.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cfg,
                                                        input logic [9:0] sample);
    return {cfg, sample, 2'b00};
  endfunction

endpackage

// File: rtl/dac_spi_tx_phase_tick.sv
// spi_phase_tick: counts 0..CLK_DIV-1 and flags the last cycle of each
// phase. Held at zero while clr is high so the first phase after leaving
// IDLE is full length. last_next predicts that the following cycle will be
// a phase-end cycle, which lets the owner register one-cycle pulses.
module spi_phase_tick
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic last_next
);

  localparam logic [PHASE_W-1:0] LAST     = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] PRE_LAST = PHASE_W'(CLK_DIV - 2);
  localparam logic               DIV_ONE  = (CLK_DIV == 1);

  logic [PHASE_W-1:0] cnt_q;

  assign tick      = (cnt_q == LAST);
  assign last_next = tick ? DIV_ONE : (cnt_q == PRE_LAST);

  // Free-running phase counter, wrapping on the phase-end tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises each 10-bit offset-binary sample as a 16-bit SPI
// (mode 0) write frame to an MCP4911-style DAC, then pulses LDAC.
// Optional macro DAC_SPI_HOLD_EN adds a one-deep hold register so a sample
// arriving mid-frame is sent back-to-back instead of being dropped.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int          CLK_DIV  = 2,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n
);

  state_t                  state_q;
  logic [FRAME_BITS-1:0]   sreg_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic                    busy_q, done_q, overrun_q;
  logic                    cs_n_q, sck_q, ld_n_q;

  logic                    tick, last_next;
  logic                    frame_end;
  logic                    start_d;
  logic [9:0]              start_sample_d;
  logic [FRAME_BITS-1:0]   start_frame_d;

`ifdef DAC_SPI_HOLD_EN
  logic       hold_valid_q;
  logic [9:0] hold_data_q;
`endif

  spi_phase_tick #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk       (sysclk),
    .rst_n     (rst_n),
    .clr       (state_q == IDLE),
    .tick      (tick),
    .last_next (last_next)
  );

  assign frame_end     = (state_q == LDAC) && tick;
  assign start_frame_d = build_frame(CFG_BITS, start_sample_d);

  // Decide whether a new frame starts on this edge and with which sample.
  always_comb begin
    start_d        = 1'b0;
    start_sample_d = data_in;
    if (state_q == IDLE && load) begin
      start_d = 1'b1;
    end
`ifdef DAC_SPI_HOLD_EN
    // A held sample wins; a load landing on the done cycle goes straight out.
    if (frame_end) begin
      if (hold_valid_q) begin
        start_d        = 1'b1;
        start_sample_d = hold_data_q;
      end else if (load) begin
        start_d = 1'b1;
      end
    end
`endif
  end

  // Frame FSM with registered SPI/LDAC outputs; sdi is the shift MSB.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      ld_n_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (start_d) begin
        state_q   <= SHIFT;
        sreg_q    <= start_frame_d;
        bit_cnt_q <= BIT_W'(FRAME_BITS - 1);
        busy_q    <= 1'b1;
        cs_n_q    <= 1'b0;
        sck_q     <= 1'b0;
        ld_n_q    <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: if (tick) begin
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              if (bit_cnt_q == '0) begin
                state_q <= CS_HOLD;
                sreg_q  <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
                sreg_q    <= {sreg_q[FRAME_BITS-2:0], 1'b0};
              end
            end
          end
          CS_HOLD: if (tick) begin
            state_q <= CS_HIGH;
            cs_n_q  <= 1'b1;
          end
          CS_HIGH: if (tick) begin
            state_q <= LDAC;
            ld_n_q  <= 1'b0;
            done_q  <= last_next;
          end
          LDAC: begin
            if (frame_end) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ld_n_q  <= 1'b1;
            end else begin
              done_q <= last_next;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef DAC_SPI_HOLD_EN
  // Hold register: keeps the newest mid-frame sample; flags a lost one.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= load && busy_q && hold_valid_q && !frame_end;
      if (load && busy_q && !(frame_end && !hold_valid_q)) begin
        hold_data_q  <= data_in;
        hold_valid_q <= 1'b1;
      end else if (frame_end) begin
        hold_valid_q <= 1'b0;
      end
    end
  end
`else
  // Any load during a frame is dropped and reported the next cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= load && busy_q;
    end
  end
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = sreg_q[FRAME_BITS-1];
  assign dac_ld_n = ld_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] data0, data1;
  logic       load0, load1;
  logic       busy0, done0, ovr0, cs0, sck0, sdi0, ld0;
  logic       busy1, done1, ovr1, cs1, sck1, sdi1, ld1;

  dac_spi_tx #(.CLK_DIV(2), .CFG_BITS(4'b0011)) u_dut (
    .sysclk(clk), .rst_n(rst_n), .data_in(data0), .load(load0),
    .busy(busy0), .done(done0), .overrun(ovr0), .dac_cs_n(cs0),
    .dac_sck(sck0), .dac_sdi(sdi0), .dac_ld_n(ld0)
  );

  dac_spi_tx #(.CLK_DIV(1), .CFG_BITS(4'b0011)) u_dut1 (
    .sysclk(clk), .rst_n(rst_n), .data_in(data1), .load(load1),
    .busy(busy1), .done(done1), .overrun(ovr1), .dac_cs_n(cs1),
    .dac_sck(sck1), .dac_sdi(sdi1), .dac_ld_n(ld1)
  );

  // Observation word: [6]busy [5]done [4]overrun [3]cs_n [2]sck [1]sdi [0]ld_n
  localparam logic [6:0] IDLE_OBS = 7'b0001001;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          sel;
    logic [9:0]  d;
    bit          wiggle;
    logic [15:0] exp_word;
    int          exp_busy;
    int          exp_ldn;
    int          exp_cs;
    int          exp_span;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [6:0] obs(input int sel);
    if (sel != 0) return {busy1, done1, ovr1, cs1, sck1, sdi1, ld1};
    return {busy0, done0, ovr0, cs0, sck0, sdi0, ld0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic [9:0] d, input logic l);
    if (sel != 0) begin
      data1 = d; load1 = l;
    end else begin
      data0 = d; load0 = l;
    end
  endtask

  // Issue one load, then watch the frame until busy drops (or stop_rise rises seen).
  task automatic run_frame(input int sel, input logic [9:0] d, input bit wiggle,
                           input int stop_rise,
                           output logic [15:0] word, output int busy_n,
                           output int ldn_n, output int done_c, output int rises,
                           output int cs_n_cnt, output int ovr_n, output int span,
                           output logic [6:0] last_o);
    logic [6:0] o;
    logic       prev_sck;
    int         first_rise, last_rise;
    word = '0; busy_n = 0; ldn_n = 0; done_c = 0; rises = 0;
    cs_n_cnt = 0; ovr_n = 0; span = 0; prev_sck = 1'b0;
    first_rise = 0; last_rise = 0; o = '0;
    set_in(sel, d, 1'b1);
    @(negedge clk);
    set_in(sel, d, 1'b0);
    for (int c = 1; c <= 400; c++) begin
      o = obs(sel);
      if (!o[6]) break;
      busy_n++;
      if (!o[0]) ldn_n++;
      if (o[5]) done_c = c;
      if (!o[3]) cs_n_cnt++;
      if (o[4]) ovr_n++;
      if (o[2] && !prev_sck) begin
        word = {word[14:0], o[1]};
        rises++;
        if (rises == 1) first_rise = c;
        last_rise = c;
      end
      prev_sck = o[2];
      if (stop_rise > 0 && rises == stop_rise) break;
      if (wiggle) set_in(sel, 10'($urandom), 1'b0);
      @(negedge clk);
    end
    span = last_rise - first_rise;
    last_o = o;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic [15:0] word;
    int busy_n, ldn_n, done_c, rises, cs_n_cnt, ovr_n, span;
    logic [6:0] last_o;
    run_frame(v.sel, v.d, v.wiggle, 0, word, busy_n, ldn_n, done_c, rises,
              cs_n_cnt, ovr_n, span, last_o);
    $display("vec %0d: div_sel=%0d data=0x%03h word=0x%04h busy=%0d done@%0d ldn=%0d",
             idx, v.sel, v.d, word, busy_n, done_c, ldn_n);
    check($sformatf("vec%0d word", idx), 32'(word), 32'(v.exp_word));
    check($sformatf("vec%0d busy_len", idx), busy_n, v.exp_busy);
    check($sformatf("vec%0d done_cycle", idx), done_c, v.exp_busy);
    check($sformatf("vec%0d ldac_len", idx), ldn_n, v.exp_ldn);
    check($sformatf("vec%0d cs_low_len", idx), cs_n_cnt, v.exp_cs);
    check($sformatf("vec%0d sck_rises", idx), rises, 16);
    check($sformatf("vec%0d sck_span", idx), span, v.exp_span);
    check($sformatf("vec%0d overrun", idx), ovr_n, 0);
    check($sformatf("vec%0d idle_after", idx), 32'(last_o), 32'(IDLE_OBS));
    @(negedge clk);
  endtask

  initial begin
    logic [6:0]  o;
    logic [31:0] stream;
    logic [15:0] word;
    logic        prev_sck;
    int busy_n, ldn_n, done_c, rises, cs_n_cnt, ovr_n, span;
    int n_done, n_ovr, ovr_cyc, first_idle, n_busy;
    logic [6:0] last_o;

    vecs[0] = '{0, 10'h2A5, 1'b0, 16'h3A94, 70, 2, 66, 60};
    vecs[1] = '{0, 10'h000, 1'b0, 16'h3000, 70, 2, 66, 60};
    vecs[2] = '{0, 10'h3FF, 1'b0, 16'h3FFC, 70, 2, 66, 60};
    vecs[3] = '{0, 10'h2A5, 1'b1, 16'h3A94, 70, 2, 66, 60};
    vecs[4] = '{1, 10'h3FF, 1'b0, 16'h3FFC, 35, 1, 33, 30};
    vecs[5] = '{1, 10'h2A5, 1'b0, 16'h3A94, 35, 1, 33, 30};
    vecs[6] = '{1, 10'h001, 1'b1, 16'h3004, 35, 1, 33, 30};

    // Reset state
    rst_n = 1'b0;
    set_in(0, 10'h0, 1'b0);
    set_in(1, 10'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_obs_div2", 32'(obs(0)), 32'(IDLE_OBS));
    check("reset_obs_div1", 32'(obs(1)), 32'(IDLE_OBS));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'(obs(0)), 32'(IDLE_OBS));

    // Table-driven frames
    for (int i = 0; i < 7; i++) apply_vec(i, vecs[i]);

    // Load during a frame: dropped (or held, with the hold feature)
    stream = '0; prev_sck = 1'b0; n_done = 0; n_ovr = 0; ovr_cyc = 0;
    first_idle = 0; n_busy = 0; rises = 0;
`ifdef DAC_SPI_HOLD_EN
    set_in(0, 10'h001, 1'b1);
`else
    set_in(0, 10'h2A5, 1'b1);
`endif
    @(negedge clk);
    set_in(0, 10'h000, 1'b0);
    for (int c = 1; c <= 200; c++) begin
      o = obs(0);
      if (o[6]) n_busy++;
      if (!o[6] && first_idle == 0) first_idle = c;
      if (o[5]) n_done++;
      if (o[4]) begin n_ovr++; ovr_cyc = c; end
      if (o[2] && !prev_sck) begin stream = {stream[30:0], o[1]}; rises++; end
      prev_sck = o[2];
`ifdef DAC_SPI_HOLD_EN
      if (c == 10) set_in(0, 10'h002, 1'b1);
      else if (c == 20) set_in(0, 10'h003, 1'b1);
      else set_in(0, 10'h000, 1'b0);
`else
      if (c == 10) set_in(0, 10'h111, 1'b1);
      else set_in(0, 10'h000, 1'b0);
`endif
      @(negedge clk);
    end
`ifdef DAC_SPI_HOLD_EN
    $display("hold seq: stream=0x%08h busy=%0d idle@%0d dones=%0d overruns=%0d",
             stream, n_busy, first_idle, n_done, n_ovr);
    check("hold_words", stream, 32'h3004300C);
    check("hold_rises", rises, 32);
    check("hold_busy_len", n_busy, 140);
    check("hold_first_idle", first_idle, 141);
    check("hold_dones", n_done, 2);
    check("hold_overruns", n_ovr, 1);
    check("hold_overrun_cycle", ovr_cyc, 21);
`else
    $display("overrun seq: word=0x%04h busy=%0d dones=%0d overruns=%0d @%0d",
             stream[15:0], n_busy, n_done, n_ovr, ovr_cyc);
    check("ovr_word", 32'(stream[15:0]), 32'h3A94);
    check("ovr_rises", rises, 16);
    check("ovr_busy_len", n_busy, 70);
    check("ovr_dones", n_done, 1);
    check("ovr_count", n_ovr, 1);
    check("ovr_cycle", ovr_cyc, 11);
`endif

    // Reset during bit 7 (high phase of the ninth SCK)
    run_frame(0, 10'h2A5, 1'b0, 9, word, busy_n, ldn_n, done_c, rises,
              cs_n_cnt, ovr_n, span, last_o);
    check("midrst_prefix", 32'(word[8:0]), 32'(9'b0011_10101));
    #2;
    rst_n = 1'b0;
    #1;
    o = obs(0);
    $display("mid-frame reset: obs=0x%02h", o);
    check("midrst_cs_n", 32'(o[3]), 32'd1);
    check("midrst_sck", 32'(o[2]), 32'd0);
    check("midrst_busy", 32'(o[6]), 32'd0);
    check("midrst_all", 32'(o), 32'(IDLE_OBS));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_vec(7, '{0, 10'h155, 1'b0, 16'h3554, 70, 2, 66, 60});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Downstream of the audio processor stage; consumes the registered 10-bit offset-binary DAC sample.
- Serialises each sample as a 16-bit write frame to an MCP4911-style SPI DAC, then pulses LDAC so the analogue output updates.
- One frame per sample strobe; the strobe is the same per-sample pulse that paces the processor.

Parameters:
- CLK_DIV, 2: sysclk cycles per SCK half-period (legal range 1..255).
- CFG_BITS, 4'b0011: frame bits [15:12] = {write=0, BUF=0, GA=1 (1x gain), SHDN=1 (active)}.

Ports:
- sysclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  10  offset-binary sample; captured on an accepted load.
- load  in  1  single-cycle sample strobe.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse on the final cycle of a frame.
- overrun  out  1  one-cycle pulse when a load is lost.
- dac_cs_n  out  1  chip select, active low.
- dac_sck  out  1  SPI clock, mode 0 (idle low, DAC samples on rising edge).
- dac_sdi  out  1  serial data, MSB first.
- dac_ld_n  out  1  LDAC, active low.

Behaviour:
- Reset (asynchronous, also mid-frame), all outputs forced immediately to:
  - dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ld_n=1
  - busy=0, done=0, overrun=0
  - FSM=IDLE; counters and shift register cleared.
- Frame word: {CFG_BITS, data_in[9:0], 2'b00}, latched into a 16-bit shift register.
- Load accept: load=1 while FSM=IDLE.
  - Capture happens on that edge.
  - busy, dac_cs_n=0 and dac_sdi=bit15 are registered outputs, valid from the next cycle.
- FSM states and outputs:
  - IDLE: outputs at their reset values.
  - SHIFT: 16 bits, 2*CLK_DIV cycles each.
    - Low phase: CLK_DIV cycles, dac_sck=0, dac_sdi = current bit (changes only at the start of the low phase).
    - High phase: CLK_DIV cycles, dac_sck=1.
    - After the high phase of bit 0, go to CS_HOLD.
  - CS_HOLD: CLK_DIV cycles, dac_cs_n=0, dac_sck=0.
  - CS_HIGH: CLK_DIV cycles, dac_cs_n=1.
  - LDAC: CLK_DIV cycles, dac_ld_n=0. done=1 on the last cycle, then IDLE.
- Timing:
  - busy is high for exactly 35*CLK_DIV consecutive cycles (70 at the default).
  - Minimum sample period is 35*CLK_DIV+1 cycles.
- Counters:
  - Phase counter: 8 bits, counts 0..CLK_DIV-1 and wraps.
  - Bit counter: 4 bits, counts 15 down to 0.
- Boundaries:
  - A load while busy=1, including the done cycle, is not accepted (see the optional feature).
  - data_in is ignored except on the accept edge; changing it mid-frame has no effect.
  - With CLK_DIV=1, SCK runs at sysclk/2 and every state lasts exactly 1 cycle.

Optional Feature:
- Macro: DAC_SPI_HOLD_EN.
- Defined:
  - A one-deep hold register captures data_in on any load while busy=1; a newer load overwrites it.
  - overrun pulses only when an occupied hold entry is overwritten.
  - After LDAC, FSM goes directly to SHIFT with the held word; the next frame's first cycle immediately follows done, and busy stays high.
- Undefined:
  - Every load while busy=1 is dropped and overrun pulses the following cycle.

Decomposition:
- Package dac_spi_pkg holds:
  - FRAME_BITS=16 and CFG field bit positions.
  - The FSM state encoding (IDLE, SHIFT, CS_HOLD, CS_HIGH, LDAC).
  - Phase and bit counter widths.
- One sub-module, spi_phase_tick: a CLK_DIV counter with async active-low reset that emits a phase-end tick; it is cleared when leaving IDLE.
- The FSM and shift register stay in dac_spi_tx.

Test Plan:
- Basic frame: CLK_DIV=2, data_in=10'h2A5, one load pulse -> bits on dac_sdi at the 16 SCK rising edges = 16'h3A94; busy high 70 cycles; dac_ld_n low 2 cycles; done on cycle 70.
- SCK timing: CLK_DIV=1, data_in=10'h3FF -> SCK period 2 cycles; word 16'h3FFC; busy high 35 cycles.
- Overrun (macro off): second load 10 cycles after the first -> second sample dropped, overrun pulses once, only one frame emitted.
- Hold (DAC_SPI_HOLD_EN): loads of 10'h001, then 10'h002 and 10'h003 while busy -> frames 16'h3004 and 16'h300C back-to-back, busy high continuously, overrun pulses once.
- Reset mid-frame: rst_n low during bit 7 -> same cycle dac_cs_n=1, dac_sck=0, busy=0; load of 10'h155 after release -> clean frame 16'h3554.
- Data stability: data_in toggled every cycle during a frame -> transmitted word equals the value captured on the accept edge.
